// File: rtl/cdc_a2s_rx_sink.sv
// Receive sink behind the async-to-sync CDC: four-phase Si/So capture into
// a small FIFO, presented downstream as a valid/ready stream.
module cdc_a2s_rx_sink #(
   parameter int DW    = 64,
   parameter int DEPTH = 4,
   parameter int CW    = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [DW-1:0]            Din,
   input  logic                     Si,
   output logic                     So,
   output logic [DW-1:0]            m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CW-1:0]            rx_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_ACK
   } state_t;

   state_t          r_state;
   logic            r_so;
   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_level;
   logic [CW-1:0]   r_rx_count;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;

   // Full/empty come from the registered level only; no pop-to-push bypass.
   assign w_full  = (r_level == FULL);
   assign w_empty = (r_level == '0);
   assign w_push  = (r_state == S_IDLE) && Si && !w_full;
   assign w_pop   = !w_empty && m_ready;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_so       <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_rx_count <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_push) begin
                  r_so    <= 1'b1;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               if (!Si) begin
                  r_so    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
         endcase

         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_rx_count <= r_rx_count + CW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end

         if (w_push && !w_pop) begin
            r_level <= r_level + (AW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - (AW+1)'(1);
         end
      end
   end

   // Storage carries no reset; contents are don't-care until written.
   always_ff @(posedge CLK) begin
      if (!RESET && w_push) begin
         r_mem[r_wr_ptr] <= Din;
      end
   end

   assign So       = r_so;
   assign m_valid  = !w_empty;
   assign m_data   = r_mem[r_rd_ptr];
   assign level    = r_level;
   assign rx_count = r_rx_count;

endmodule
